// File: rtl/ap_sched_pkg.sv
// Shared definitions for the ap_start scheduler.
//   ch_state_e : per-channel FSM state
//   MIN_PERIOD : shortest period a channel will run at
//   eff_period : clamps a programmed period to at least MIN_PERIOD
package ap_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    RUN,
    DONE_OS
  } ch_state_e;

  localparam logic [63:0] MIN_PERIOD = 64'd2;

  // A period of 0 or 1 cannot be honoured by the reload scheme, so it runs as 2.
  function automatic logic [63:0] eff_period(input logic [63:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/ap_start_chan.sv
// One scheduler channel: period counter, ap_ctrl_hs start FSM, one-deep
// pending trigger buffer and saturating dropped-trigger counter.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   en_i            channel enable; low forces IDLE and clears counter/pending
//   one_shot_i      stop in DONE_OS after the first completed run
//   period_i        period value, latched on cfg_load_i
//   cfg_load_i      latch period_i (used at the next counter reload)
//   clr_miss_i      clear miss counter and overrun flag
//   ap_ready_i      core accepted its inputs
//   ap_done_i       core finished
//   ap_start_o      start request (registered)
//   busy_o          state is START or RUN (registered)
//   overrun_o       sticky dropped-trigger flag
//   miss_cnt_o      saturating dropped-trigger count
module ap_start_chan
  import ap_sched_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MISS_W     = 8,
  parameter int DEF_PERIOD = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              one_shot_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic              cfg_load_i,
  input  logic              clr_miss_i,
  input  logic              ap_ready_i,
  input  logic              ap_done_i,
  output logic              ap_start_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [MISS_W-1:0] miss_cnt_o
);

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  ch_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q;
  logic [CNT_W-1:0]  reload;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              start_q, busy_q;
  logic              active, tick, done_evt, drop;

  assign reload   = CNT_W'(eff_period(64'(per_q)) - 64'd1);
  assign active   = (state_q == START) || (state_q == RUN);
  // The counter free-runs through WAIT/START/RUN so ticks stay on a fixed
  // grid regardless of how long the core takes.
  assign tick     = (active || (state_q == WAIT)) && (cnt_q == '0);
  // Ready and done in the same START cycle completes the whole handshake.
  assign done_evt = (state_q == START) ? (ap_ready_i && ap_done_i)
                                       : ((state_q == RUN) && ap_done_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = reload;
        end
        WAIT: begin
          if (tick) begin
            state_d = START;
            cnt_d   = reload;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        START, RUN: begin
          cnt_d = tick ? reload : cnt_q - 1'b1;
          if (done_evt) begin
            if (one_shot_i) begin
              state_d = DONE_OS;
              pend_d  = 1'b0;
            end else if (pend_q) begin
              // Serve the buffered trigger; a tick landing now refills it.
              state_d = START;
              pend_d  = tick;
            end else if (tick) begin
              state_d = START;
            end else begin
              state_d = WAIT;
            end
          end else begin
            if ((state_q == START) && ap_ready_i) state_d = RUN;
            if (tick) begin
              if (pend_q) drop = 1'b1;
              else        pend_d = 1'b1;
            end
          end
        end
        DONE_OS: state_d = DONE_OS;
        default: state_d = IDLE;
      endcase
    end
  end

  // A clear coinciding with a drop still records that drop.
  always_comb begin
    if (clr_miss_i) begin
      ovr_d  = drop;
      miss_d = drop ? MISS_W'(1) : '0;
    end else begin
      ovr_d  = ovr_q | drop;
      miss_d = (drop && (miss_q != MISS_MAX)) ? miss_q + 1'b1 : miss_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= CNT_W'(DEF_PERIOD);
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      miss_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_load_i) per_q <= period_i;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      miss_q  <= miss_d;
      start_q <= (state_d == START);
      busy_q  <= (state_d == START) || (state_d == RUN);
    end
  end

  assign ap_start_o = start_q;
  assign busy_o     = busy_q;
  assign overrun_o  = ovr_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: rtl/ap_start_scheduler.sv
// Periodic / one-shot ap_start generator for NUM_CH HLS cores using the
// ap_ctrl_hs handshake. Channels are independent copies of ap_start_chan.
// Ports:
//   ap_clk, ap_rst  clock, asynchronous active-high reset
//   ch_en           per-channel enable
//   one_shot        per-channel one-shot mode
//   period          packed periods, channel i at [i*CNT_W +: CNT_W]
//   cfg_load        latch all periods
//   clr_miss        clear all miss counters and overrun flags
//   ap_start        per-core start request
//   ap_ready        per-core input accepted
//   ap_done         per-core finished
//   busy            channel in START or RUN
//   overrun         sticky dropped-trigger flag per channel
//   miss_cnt        packed saturating miss counts, channel i at [i*MISS_W +: MISS_W]
module ap_start_scheduler
  import ap_sched_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int MISS_W     = 8,
  parameter int DEF_PERIOD = 1000000
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        one_shot,
  input  logic [NUM_CH*CNT_W-1:0]  period,
  input  logic                     cfg_load,
  input  logic                     clr_miss,
  output logic [NUM_CH-1:0]        ap_start,
  input  logic [NUM_CH-1:0]        ap_ready,
  input  logic [NUM_CH-1:0]        ap_done,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        overrun,
  output logic [NUM_CH*MISS_W-1:0] miss_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ap_start_chan #(
      .CNT_W      (CNT_W),
      .MISS_W     (MISS_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .clk_i      (ap_clk),
      .rst_i      (ap_rst),
      .en_i       (ch_en[i]),
      .one_shot_i (one_shot[i]),
      .period_i   (period[i*CNT_W +: CNT_W]),
      .cfg_load_i (cfg_load),
      .clr_miss_i (clr_miss),
      .ap_ready_i (ap_ready[i]),
      .ap_done_i  (ap_done[i]),
      .ap_start_o (ap_start[i]),
      .busy_o     (busy[i]),
      .overrun_o  (overrun[i]),
      .miss_cnt_o (miss_cnt[i*MISS_W +: MISS_W])
    );
  end

endmodule

// File: tb/tb_ap_start_scheduler.sv
// Directed bench for ap_start_scheduler (2 channels, 3-bit miss counters,
// reset period 7 so the reset-period behaviour is observable quickly).
module tb_ap_start_scheduler;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int MISS_W = 3;
  localparam int DEF_P  = 7;

  logic                     ap_clk;
  logic                     ap_rst;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        one_shot;
  logic [NUM_CH*CNT_W-1:0]  period;
  logic                     cfg_load;
  logic                     clr_miss;
  logic [NUM_CH-1:0]        ap_start;
  logic [NUM_CH-1:0]        ap_ready;
  logic [NUM_CH-1:0]        ap_done;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH*MISS_W-1:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  logic seen;

  ap_start_scheduler #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .MISS_W     (MISS_W),
    .DEF_PERIOD (DEF_P)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ch_en    (ch_en),
    .one_shot (one_shot),
    .period   (period),
    .cfg_load (cfg_load),
    .clr_miss (clr_miss),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .busy     (busy),
    .overrun  (overrun),
    .miss_cnt (miss_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic clk1();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles until ap_start[ch] is seen high (bounded; -1 on timeout).
  task automatic wait_start(input int ch, output int cnt);
    cnt = -1;
    for (int k = 1; k <= 60; k++) begin
      clk1();
      if (ap_start[ch]) begin
        cnt = k;
        break;
      end
    end
  endtask

  // Core response starting in the cycle ap_start is first seen:
  // ready rd cycles later, done dd cycles after ready (dd=0: same cycle).
  task automatic serve(input int ch, input int rd, input int dd);
    repeat (rd) clk1();
    ap_ready[ch] = 1'b1;
    if (dd == 0) ap_done[ch] = 1'b1;
    clk1();
    ap_ready[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
    if (dd > 0) begin
      repeat (dd - 1) clk1();
      ap_done[ch] = 1'b1;
      clk1();
      ap_done[ch] = 1'b0;
    end
  endtask

  initial begin
    ap_rst = 1'b1; ch_en = '0; one_shot = '0; period = '0;
    cfg_load = 1'b0; clr_miss = 1'b0; ap_ready = '0; ap_done = '0;
    repeat (2) clk1();
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_miss", miss_cnt, 0);
    ap_rst = 1'b0;
    clk1();

    // Periodic, period 10, ready after 1, done 3 later
    period = {32'd0, 32'd10}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("p10_first_start", n, 11);
    serve(0, 1, 3);   check("p10_idle_after_done", busy[0], 0);
    wait_start(0, n); check("p10_second_start", n, 5);
    serve(0, 1, 3);
    wait_start(0, n); check("p10_third_start", n, 5);
    serve(0, 1, 3);
    check("p10_no_overrun", overrun[0], 0);
    check("p10_no_miss", miss_cnt[2:0], 0);
    ch_en[0] = 1'b0; clk1();

    // Period 4 with a slow core: pending, overruns, restart after done
    period = {32'd0, 32'd4}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("p4_first_start", n, 5);
    clk1();
    check("p4_start_held", ap_start[0], 1);
    ap_ready[0] = 1'b1;
    clk1();
    ap_ready[0] = 1'b0;
    check("p4_start_fell", ap_start[0], 0);
    check("p4_busy_run", busy[0], 1);
    repeat (2) clk1();
    check("p4_pending_no_overrun", overrun[0], 0);
    repeat (4) clk1();
    check("p4_overrun_set", overrun[0], 1);
    check("p4_miss1", miss_cnt[2:0], 1);
    repeat (4) clk1();
    check("p4_miss2", miss_cnt[2:0], 2);
    clk1();
    ap_done[0] = 1'b1;
    clk1();
    ap_done[0] = 1'b0;
    check("p4_restart", ap_start[0], 1);
    check("p4_miss_hold", miss_cnt[2:0], 2);

    // Disable while in START
    ch_en[0] = 1'b0;
    clk1();
    check("abort_start", ap_start[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_miss_kept", miss_cnt[2:0], 2);
    check("abort_ovr_kept", overrun[0], 1);
    ch_en[0] = 1'b1;
    wait_start(0, n); check("abort_reenable", n, 5);
    ch_en[0] = 1'b0; clk1();
    clr_miss = 1'b1; clk1(); clr_miss = 1'b0;
    check("clr_overrun", overrun[0], 0);
    check("clr_miss", miss_cnt[2:0], 0);

    // One-shot, period 5
    period = {32'd0, 32'd5}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    one_shot[0] = 1'b1; ch_en[0] = 1'b1;
    wait_start(0, n); check("os_first_start", n, 6);
    serve(0, 0, 0);
    check("os_busy_done", busy[0], 0);
    seen = 1'b0;
    repeat (20) begin
      clk1();
      seen = seen | ap_start[0];
    end
    check("os_no_more_starts", seen, 0);
    ch_en[0] = 1'b0; clk1();
    ch_en[0] = 1'b1;
    wait_start(0, n); check("os_retrigger", n, 6);
    serve(0, 0, 0);
    check("os_stop_again", ap_start[0], 0);
    ch_en[0] = 1'b0; one_shot[0] = 1'b0; clk1();

    // Period 1 and period 0 both run as 2
    period = {32'd0, 32'd1}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("p1_first_start", n, 3);
    serve(0, 0, 0);
    wait_start(0, n); check("p1_period_a", n, 1);
    serve(0, 0, 0);
    wait_start(0, n); check("p1_period_b", n, 1);
    serve(0, 0, 0);
    ch_en[0] = 1'b0; clk1();
    period = {32'd0, 32'd0}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("p0_first_start", n, 3);
    serve(0, 0, 0);
    wait_start(0, n); check("p0_period", n, 1);
    serve(0, 0, 0);
    ch_en[0] = 1'b0; clk1();

    // Channel 1 (period 0) with an unresponsive core: saturation and clear-vs-drop
    ch_en[1] = 1'b1;
    wait_start(1, n); check("ch1_first_start", n, 3);
    repeat (37) clk1();
    check("ch1_miss_sat", miss_cnt[5:3], 7);
    check("ch1_overrun", overrun[1], 1);
    check("ch0_untouched", miss_cnt[2:0], 0);
    clr_miss = 1'b1;
    clk1();
    check("clr_with_drop_miss", miss_cnt[5:3], 1);
    check("clr_with_drop_ovr", overrun[1], 1);
    clk1();
    clr_miss = 1'b0;
    check("clr_no_drop_miss", miss_cnt[5:3], 0);
    check("clr_no_drop_ovr", overrun[1], 0);
    clk1();
    check("ch1_miss_after_clr", miss_cnt[5:3], 1);
    ch_en[1] = 1'b0; clk1();

    // Asynchronous reset mid-RUN
    period = {32'd0, 32'd10}; cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("rr_first_start", n, 11);
    ap_ready[0] = 1'b1;
    clk1();
    ap_ready[0] = 1'b0;
    check("rr_busy_run", busy[0], 1);
    #3;
    ap_rst = 1'b1;
    #1;
    check("rr_async_start", ap_start, 0);
    check("rr_async_busy", busy, 0);
    check("rr_async_overrun", overrun, 0);
    check("rr_async_miss", miss_cnt, 0);
    ch_en = '0;
    clk1();
    ap_rst = 1'b0;
    ch_en[0] = 1'b1;
    wait_start(0, n); check("rr_def_period", n, DEF_P + 1);
    ch_en[0] = 1'b0; clk1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
